// File: rtl/dii_packet_receiver.sv
// DII slave endpoint: buffers one first/last-delimited packet of 16-bit flits and
// holds header, payload, length and error flag until acknowledged. Optional
// statistics counters are enabled by defining DII_RX_STATS_EN.
module dii_packet_receiver #(
  parameter int MAX_LEN = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [15:0]                   in_data,
  input  logic                          in_first,
  input  logic                          in_last,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          out_valid,
  input  logic                          out_ack,
  output logic [15:0]                   out_dest,
  output logic [15:0]                   out_src,
  output logic [15:0]                   out_flags,
  output logic [16*(MAX_LEN-3)-1:0]     out_payload,
  output logic [$clog2(MAX_LEN+1)-1:0]  out_len,
`ifdef DII_RX_STATS_EN
  input  logic                          stat_clr,
  output logic [15:0]                   stat_pkts,
  output logic [15:0]                   stat_errs,
`endif
  output logic                          out_err
);

  localparam int CW = $clog2(MAX_LEN+1);

  typedef enum logic [1:0] {IDLE, RECV, DROP, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [15:0]   mem_q [MAX_LEN];
  logic [15:0]   mem_d [MAX_LEN];
  logic          err_q, err_d;
  logic          out_valid_q, out_valid_d;
  logic          in_ready_q, in_ready_d;
  logic          xfer_s;

  assign xfer_s = in_valid & in_ready_q;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    mem_d       = mem_q;
    err_d       = err_q;
    case (state_q)
      IDLE, RECV, DROP: begin
        if (xfer_s && in_first) begin
          // A first flit always restarts, abandoning any partial packet.
          mem_d    = '{default: 16'h0000};
          mem_d[0] = in_data;
          count_d  = CW'(1);
          err_d    = in_last;
          state_d  = in_last ? DONE : RECV;
        end else if (xfer_s && state_q == RECV) begin
          if (count_q < CW'(MAX_LEN)) begin
            for (int i = 0; i < MAX_LEN; i++) begin
              if (count_q == CW'(i)) begin
                mem_d[i] = in_data;
              end else begin
                mem_d[i] = mem_q[i];
              end
            end
            count_d = count_q + CW'(1);
            if (in_last) begin
              state_d = DONE;
              err_d   = (count_q < CW'(2));
            end else begin
              state_d = RECV;
            end
          end else begin
            err_d   = 1'b1;
            state_d = in_last ? DONE : DROP;
          end
        end else if (xfer_s && state_q == DROP) begin
          state_d = in_last ? DONE : DROP;
        end else begin
          state_d = state_q;
        end
      end
      DONE: begin
        if (out_ack) begin
          state_d = IDLE;
          count_d = '0;
          mem_d   = '{default: 16'h0000};
          err_d   = 1'b0;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
        mem_d   = '{default: 16'h0000};
        err_d   = 1'b0;
      end
    endcase
    out_valid_d = (state_d == DONE);
    in_ready_d  = (state_d != DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      mem_q       <= '{default: 16'h0000};
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      mem_q       <= mem_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_err   = err_q;
  assign out_len   = count_q;
  assign out_dest  = mem_q[0];
  assign out_src   = mem_q[1];
  assign out_flags = mem_q[2];

  for (genvar g = 3; g < MAX_LEN; g++) begin : g_payload
    assign out_payload[16*(g-3) +: 16] = mem_q[g];
  end

`ifdef DII_RX_STATS_EN
  logic [15:0] stat_pkts_q, stat_errs_q;
  logic        done_entry_s;

  assign done_entry_s = (state_q != DONE) && (state_d == DONE);

  // Saturating packet/error counters; clear takes priority over counting.
  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      stat_pkts_q <= 16'h0000;
      stat_errs_q <= 16'h0000;
    end else if (done_entry_s) begin
      if (stat_pkts_q != 16'hFFFF) stat_pkts_q <= stat_pkts_q + 16'h0001;
      if (err_d && stat_errs_q != 16'hFFFF) stat_errs_q <= stat_errs_q + 16'h0001;
    end
  end

  assign stat_pkts = stat_pkts_q;
  assign stat_errs = stat_errs_q;
`endif

endmodule

// File: tb/tb_dii_packet_receiver.sv
// Directed self-checking bench for dii_packet_receiver (MAX_LEN = 8).
module tb_dii_packet_receiver;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_data;
  logic        in_first, in_last, in_valid, in_ready;
  logic        out_valid, out_ack, out_err;
  logic [15:0] out_dest, out_src, out_flags;
  logic [79:0] out_payload;
  logic [3:0]  out_len;
`ifdef DII_RX_STATS_EN
  logic        stat_clr;
  logic [15:0] stat_pkts, stat_errs;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  dii_packet_receiver #(.MAX_LEN(8)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_first(in_first), .in_last(in_last),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ack(out_ack),
    .out_dest(out_dest), .out_src(out_src), .out_flags(out_flags),
    .out_payload(out_payload), .out_len(out_len),
`ifdef DII_RX_STATS_EN
    .stat_clr(stat_clr), .stat_pkts(stat_pkts), .stat_errs(stat_errs),
`endif
    .out_err(out_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d, input logic f, input logic l);
    in_data  = d;
    in_first = f;
    in_last  = l;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic ack();
    out_ack = 1'b1;
    tick();
    out_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_data = 16'h0000; in_first = 1'b0; in_last = 1'b0;
    in_valid = 1'b0; out_ack = 1'b0;
`ifdef DII_RX_STATS_EN
    stat_clr = 1'b0;
`endif
    tick(); tick();
    rst = 1'b0;

    // reset state
    chk("rst_valid", 80'(out_valid), 80'h0);
    chk("rst_ready", 80'(in_ready), 80'h1);
    chk("rst_len",   80'(out_len), 80'h0);
    chk("rst_err",   80'(out_err), 80'h0);
    chk("rst_dest",  80'(out_dest), 80'h0);

    // 1: basic 4-flit packet
    send(16'h0001, 1'b1, 1'b0);
    send(16'h0002, 1'b0, 1'b0);
    send(16'h4000, 1'b0, 1'b0);
    chk("t1_valid_early", 80'(out_valid), 80'h0);
    send(16'hBEEF, 1'b0, 1'b1);
    chk("t1_valid", 80'(out_valid), 80'h1);
    chk("t1_dest",  80'(out_dest), 80'h0001);
    chk("t1_src",   80'(out_src), 80'h0002);
    chk("t1_flags", 80'(out_flags), 80'h4000);
    chk("t1_pay",   out_payload, 80'h0000_0000_0000_0000_BEEF);
    chk("t1_len",   80'(out_len), 80'h4);
    chk("t1_err",   80'(out_err), 80'h0);
    chk("t1_ready", 80'(in_ready), 80'h0);
    tick();
    chk("t1_hold", 80'(out_dest), 80'h0001);
    ack();
    chk("t1_ack_valid", 80'(out_valid), 80'h0);
    chk("t1_ack_ready", 80'(in_ready), 80'h1);
    chk("t1_ack_dest",  80'(out_dest), 80'h0);
    chk("t1_ack_len",   80'(out_len), 80'h0);

    // 2: 10-flit overflow
    for (int i = 0; i < 10; i++) begin
      send(16'h0010 + 16'(i), (i == 0), (i == 9));
      if (i == 8) chk("t2_drop_ready", 80'(in_ready), 80'h1);
    end
    chk("t2_valid", 80'(out_valid), 80'h1);
    chk("t2_len",   80'(out_len), 80'h8);
    chk("t2_err",   80'(out_err), 80'h1);
    chk("t2_dest",  80'(out_dest), 80'h0010);
    chk("t2_pay",   out_payload, 80'h0017_0016_0015_0014_0013);
    ack();

    // 3: short 2-flit packet
    send(16'h0003, 1'b1, 1'b0);
    send(16'h0004, 1'b0, 1'b1);
    chk("t3_len",   80'(out_len), 80'h2);
    chk("t3_err",   80'(out_err), 80'h1);
    chk("t3_src",   80'(out_src), 80'h0004);
    chk("t3_flags", 80'(out_flags), 80'h0);
    ack();

    // 4: stray flit in IDLE discarded
    send(16'h1111, 1'b0, 1'b0);
    chk("t4_stray_len", 80'(out_len), 80'h0);
    send(16'h000A, 1'b1, 1'b0);
    send(16'h000B, 1'b0, 1'b0);
    send(16'h000C, 1'b0, 1'b1);
    chk("t4_dest",  80'(out_dest), 80'h000A);
    chk("t4_flags", 80'(out_flags), 80'h000C);
    chk("t4_len",   80'(out_len), 80'h3);
    chk("t4_err",   80'(out_err), 80'h0);
    chk("t4_pay",   out_payload, 80'h0);
    ack();

    // 5: reset mid-packet
    send(16'h0021, 1'b1, 1'b0);
    send(16'h0022, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_len",   80'(out_len), 80'h0);
    chk("t5_dest",  80'(out_dest), 80'h0);
    chk("t5_valid", 80'(out_valid), 80'h0);
    send(16'h0031, 1'b1, 1'b0);
    send(16'h0032, 1'b0, 1'b0);
    send(16'h0033, 1'b0, 1'b1);
    chk("t5_dest2", 80'(out_dest), 80'h0031);
    chk("t5_flags", 80'(out_flags), 80'h0033);
    chk("t5_err",   80'(out_err), 80'h0);
    ack();

    // mid-packet restart on a new first flit
    send(16'h0041, 1'b1, 1'b0);
    send(16'h0042, 1'b0, 1'b0);
    send(16'h0043, 1'b0, 1'b0);
    send(16'h0044, 1'b0, 1'b0);
    send(16'h0051, 1'b1, 1'b0);
    send(16'h0052, 1'b0, 1'b0);
    send(16'h0053, 1'b0, 1'b1);
    chk("rs_dest", 80'(out_dest), 80'h0051);
    chk("rs_len",  80'(out_len), 80'h3);
    chk("rs_pay",  out_payload, 80'h0);
    chk("rs_err",  80'(out_err), 80'h0);
    ack();

`ifdef DII_RX_STATS_EN
    // 6: statistics
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    for (int p = 0; p < 3; p++) begin
      send(16'h0060, 1'b1, 1'b0);
      send(16'h0061, 1'b0, 1'b0);
      send(16'h0062, 1'b0, 1'b1);
      ack();
    end
    for (int i = 0; i < 9; i++) send(16'h0070, (i == 0), (i == 8));
    chk("t6_pkts", 80'(stat_pkts), 80'h4);
    chk("t6_errs", 80'(stat_errs), 80'h1);
    ack();
    send(16'h0080, 1'b1, 1'b0);
    stat_clr = 1'b1;
    send(16'h0081, 1'b0, 1'b1);
    stat_clr = 1'b0;
    chk("t6_clr_pkts", 80'(stat_pkts), 80'h0);
    chk("t6_clr_errs", 80'(stat_errs), 80'h0);
    ack();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
